kf8253_host_master: RTL
=======================

Name: kf8253_host_master

Overview:
- Host-side bus initiator for the KF8253 programmable interval timer.
- Accepts high-level commands over a valid/ready interface: program a counter, reload a count, or latch and read a count.
- Expands each command into the required sequence of 8253 control-word, data-write and data-read bus cycles.
- Sits between the CPU-side glue logic and the KF8253 CPU port, and drives that port's chip_select_n, read_enable_n, write_enable_n, address and data lines.

Parameters:
- STROBE_CYCLES, 2, clocks that chip_select_n and the read/write strobe are held low per bus cycle; minimum 1.
- RECOVERY_CYCLES, 1, idle clocks with all strobes high after each bus cycle; minimum 1.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  00 PROGRAM, 01 RELOAD, 10 READ, 11 reserved.
- cmd_counter  in  2  counter select, 0-2; 3 is illegal.
- cmd_rw  in  2  RL field: 01 LSB, 10 MSB, 11 LSB then MSB, 00 latch only.
- cmd_mode  in  3  counter mode (PROGRAM only).
- cmd_bcd  in  1  BCD select (PROGRAM only).
- cmd_count  in  16  count value for PROGRAM or RELOAD.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_error  out  1  qualifies rsp_valid; command rejected.
- rsp_data  out  16  READ result, otherwise 0.
- busy  out  1  a command is in progress.
- chip_select_n  out  1  to the 8253.
- read_enable_n  out  1  to the 8253.
- write_enable_n  out  1  to the 8253.
- address  out  2  to the 8253.
- data_bus_out  out  8  write data to the 8253 data_bus_in.
- data_bus_in  in  8  read data from the 8253 data_bus_out.

Behaviour:
- Reset values: strobes high, address 0, data_bus_out 0, busy 0, rsp_valid 0, rsp_error 0, rsp_data 0. cmd_ready is 1 once reset_n is high.
- Command acceptance: a command is accepted on a clock edge where cmd_valid and cmd_ready are both high. All cmd_* fields are captured at that edge. cmd_ready is low from the cycle after acceptance until the cycle rsp_valid is high, inclusive of that cycle's end; it is high again in the rsp_valid cycle.
- Control word: {cmd_counter, cmd_rw, cmd_mode, cmd_bcd}, written to address 2'b11.
- PROGRAM: write the control word, then write the count per cmd_rw:
  - 01: count[7:0].
  - 10: count[15:8].
  - 11: LSB then MSB.
  - 00: no data write.
- RELOAD: the data writes of PROGRAM only; no control word. cmd_rw=00 produces an immediate non-error response.
- READ: write the latch word {cmd_counter, 2'b00, 3'b000, 1'b0} to address 3, then read at address cmd_counter:
  - 01: LSB only, rsp_data[15:8]=0.
  - 10: MSB only, rsp_data[7:0]=0.
  - 11 or 00: LSB then MSB.
- Bus cycle FSM: IDLE → SETUP → STROBE → RECOVER.
  - SETUP (1 clock): address and data driven, strobes high.
  - STROBE (STROBE_CYCLES clocks): chip_select_n low plus write_enable_n or read_enable_n low. Address and data are held stable.
  - Read capture: data_bus_in is sampled on the last STROBE clock.
  - RECOVER (RECOVERY_CYCLES clocks): all strobes high; address and data held.
  - Sequencing: the next queued bus cycle starts with its own SETUP; after the last bus cycle the FSM returns to IDLE.
- Bus cycle length: T = 1 + STROBE_CYCLES + RECOVERY_CYCLES clocks.
- Response timing: rsp_valid is high in the clock after the final RECOVER clock, so latency is N×T + 1 from acceptance, where N is the number of bus cycles.
- busy: high from the cycle after acceptance through the last RECOVER clock.
- Strobe mutual exclusion: read_enable_n and write_enable_n are never low simultaneously. Both are only low while chip_select_n is low.
- Errors: cmd_counter=3 or cmd_op=11 produces rsp_valid with rsp_error=1 in the cycle after acceptance, with no bus activity.
- reset_n low mid-operation: strobes go high immediately (asynchronous), the command is dropped and no response is issued.
- cmd_valid is ignored while cmd_ready is low.

Decomposition:
- kf8253_host_pkg: op enum, bus FSM state enum, ADDR_CONTROL=2'b11, RL encodings, and a control-word packing function.
- Sub-module kf8253_bus_cycle: a single-cycle timing engine.
  - Inputs: start, is_read, address, wdata.
  - Outputs: strobes, rdata, done.
  - The top level holds a sequencer that issues up to 3 bus cycles per command.

Test Plan:
- PROGRAM counter 0, rw=01, mode 3, binary, count 0x0005 → write 0x16@3, then write 0x05@0. With defaults, rsp_valid arrives 9 clocks after acceptance, rsp_error=0.
- PROGRAM counter 2, rw=11, mode 2, count 0x1234 → writes 0xB4@3, 0x34@2, 0x12@2. Each write has 2 low-strobe clocks; rsp_valid arrives at 13 clocks.
- READ counter 1, rw=11, with a bus model returning 0xCD then 0xAB → write 0x40@3, read@1 twice; rsp_data=0xABCD.
- READ counter 0, rw=10, bus model returns 0x7E → rsp_data=0x7E00. Also connect a live KF8253 running mode 0 with count 0x0F and check the read value decreases over time.
- cmd_counter=3 and cmd_op=11 → rsp_error=1 one clock after acceptance; chip_select_n stays high throughout.
- Back-to-back commands with cmd_valid held high → second command accepted in the rsp_valid cycle of the first. Assert reset_n low mid-STROBE → strobes high the same cycle, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/kf8253_host_pkg.sv
// kf8253_host_pkg
//   Shared types and helpers for the KF8253 host-side bus initiator.
//   - op_e        : host command opcodes
//   - bus_state_e : states of the single bus-cycle timing engine
//   - ADDR_CONTROL: 8253 control-word register address
//   - RL_*        : read/load field encodings of the control word
//   - pack_control_word / total_cycles : control-word packing and
//     the number of bus cycles a command expands into
package kf8253_host_pkg;

  typedef enum logic [1:0] {
    OP_PROGRAM = 2'b00,
    OP_RELOAD  = 2'b01,
    OP_READ    = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    BUS_IDLE    = 2'd0,
    BUS_SETUP   = 2'd1,
    BUS_STROBE  = 2'd2,
    BUS_RECOVER = 2'd3
  } bus_state_e;

  localparam logic [1:0] ADDR_CONTROL = 2'b11;

  localparam logic [1:0] RL_LATCH = 2'b00;
  localparam logic [1:0] RL_LSB   = 2'b01;
  localparam logic [1:0] RL_MSB   = 2'b10;
  localparam logic [1:0] RL_BOTH  = 2'b11;

  function automatic logic [7:0] pack_control_word(input logic [1:0] counter,
                                                   input logic [1:0] rw,
                                                   input logic [2:0] mode,
                                                   input logic       bcd);
    return {counter, rw, mode, bcd};
  endfunction

  // Writes move 0/1/2 bytes depending on RL; a read always moves at least
  // one byte, and RL=00 on a read means the full 16-bit latched value.
  function automatic logic [1:0] total_cycles(input logic [1:0] op,
                                              input logic [1:0] rw);
    logic [1:0] wbytes;
    logic [1:0] rbytes;
    wbytes = (rw == RL_BOTH) ? 2'd2 : (rw == RL_LATCH) ? 2'd0 : 2'd1;
    rbytes = (rw == RL_LSB || rw == RL_MSB) ? 2'd1 : 2'd2;
    case (op)
      OP_PROGRAM: return 2'd1 + wbytes;
      OP_RELOAD:  return wbytes;
      OP_READ:    return 2'd1 + rbytes;
      default:    return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/kf8253_bus_cycle.sv
// kf8253_bus_cycle
//   Timing engine for one 8253 bus cycle: SETUP -> STROBE -> RECOVER.
//   A new cycle may be chained straight out of the last RECOVER clock.
//   Ports:
//     clock, reset_n        : clock, async active-low reset
//     i_start               : begin a cycle (accepted in IDLE or last RECOVER)
//     i_is_read             : 1 = read strobe, 0 = write strobe
//     i_address, i_wdata    : address / write byte for the cycle
//     i_rdata_bus           : 8253 read data, sampled on the last STROBE clock
//     o_cs_n/o_rd_n/o_wr_n  : registered strobes
//     o_address, o_wdata_bus: registered address / write data
//     o_rdata               : byte captured by the last read cycle
//     o_done                : high during the final RECOVER clock
module kf8253_bus_cycle
  import kf8253_host_pkg::*;
#(
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic       i_is_read,
  input  logic [1:0] i_address,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_rdata_bus,
  output logic       o_cs_n,
  output logic       o_rd_n,
  output logic       o_wr_n,
  output logic [1:0] o_address,
  output logic [7:0] o_wdata_bus,
  output logic [7:0] o_rdata,
  output logic       o_done
);

  localparam logic [7:0] STROBE_LAST  = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] RECOVER_LAST = 8'(RECOVERY_CYCLES - 1);

  bus_state_e r_state;
  logic [7:0] r_cnt;
  logic       r_is_read;
  logic       r_cs_n;
  logic       r_rd_n;
  logic       r_wr_n;
  logic [1:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic       w_last_recover;

  assign w_last_recover = (r_state == BUS_RECOVER) && (r_cnt == RECOVER_LAST);

  // Strobes are registered so they are glitch-free; the asynchronous reset
  // forces them high the instant reset_n falls, even mid-strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= BUS_IDLE;
      r_cnt     <= 8'd0;
      r_is_read <= 1'b0;
      r_cs_n    <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_addr    <= 2'd0;
      r_wdata   <= 8'd0;
      r_rdata   <= 8'd0;
    end else begin
      case (r_state)
        BUS_IDLE: begin
          if (i_start) begin
            r_state   <= BUS_SETUP;
            r_is_read <= i_is_read;
            r_addr    <= i_address;
            r_wdata   <= i_is_read ? 8'd0 : i_wdata;
          end
        end
        BUS_SETUP: begin
          r_state <= BUS_STROBE;
          r_cnt   <= 8'd0;
          r_cs_n  <= 1'b0;
          r_rd_n  <= ~r_is_read;
          r_wr_n  <= r_is_read;
        end
        BUS_STROBE: begin
          if (r_cnt == STROBE_LAST) begin
            if (r_is_read) r_rdata <= i_rdata_bus;
            r_state <= BUS_RECOVER;
            r_cnt   <= 8'd0;
            r_cs_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        BUS_RECOVER: begin
          if (w_last_recover) begin
            if (i_start) begin
              r_state   <= BUS_SETUP;
              r_is_read <= i_is_read;
              r_addr    <= i_address;
              r_wdata   <= i_is_read ? 8'd0 : i_wdata;
            end else begin
              r_state <= BUS_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= BUS_IDLE;
      endcase
    end
  end

  assign o_cs_n      = r_cs_n;
  assign o_rd_n      = r_rd_n;
  assign o_wr_n      = r_wr_n;
  assign o_address   = r_addr;
  assign o_wdata_bus = r_wdata;
  assign o_rdata     = r_rdata;
  assign o_done      = w_last_recover;

endmodule

// File: rtl/kf8253_host_master.sv
// kf8253_host_master
//   Host-side initiator for the KF8253 timer. Expands PROGRAM / RELOAD /
//   READ commands into up to three control-word, data-write and data-read
//   bus cycles and reports completion with a one-cycle response pulse.
//   Ports:
//     clock, reset_n                  : clock, async active-low reset
//     cmd_valid/cmd_ready, cmd_*      : command handshake and fields
//     rsp_valid, rsp_error, rsp_data  : completion pulse, error flag, READ data
//     busy                            : a command is in progress
//     chip_select_n, read_enable_n,
//     write_enable_n, address,
//     data_bus_out, data_bus_in       : 8253 CPU port
module kf8253_host_master
  import kf8253_host_pkg::*;
#(
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_counter,
  input  logic [1:0]  cmd_rw,
  input  logic [2:0]  cmd_mode,
  input  logic        cmd_bcd,
  input  logic [15:0] cmd_count,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        chip_select_n,
  output logic        read_enable_n,
  output logic        write_enable_n,
  output logic [1:0]  address,
  output logic [7:0]  data_bus_out,
  input  logic [7:0]  data_bus_in
);

  logic [1:0]  r_op;
  logic [1:0]  r_counter;
  logic [1:0]  r_rw;
  logic [2:0]  r_mode;
  logic        r_bcd;
  logic [15:0] r_count;
  logic [1:0]  r_idx;
  logic [1:0]  r_num;
  logic        r_cur_read;
  logic        r_cur_msb;
  logic [15:0] r_rd_acc;
  logic        r_busy;
  logic        r_rsp_valid;
  logic        r_rsp_error;
  logic [15:0] r_rsp_data;

  logic        w_accept;
  logic        w_err;
  logic [1:0]  w_num_new;
  logic        w_done;
  logic        w_more;
  logic        w_start;
  logic [1:0]  w_sel_op;
  logic [1:0]  w_sel_counter;
  logic [1:0]  w_sel_rw;
  logic [2:0]  w_sel_mode;
  logic        w_sel_bcd;
  logic [15:0] w_sel_count;
  logic [1:0]  w_next_idx;
  logic [1:0]  w_data_pos;
  logic        w_has_prefix;
  logic        w_cyc_read;
  logic        w_cyc_msb;
  logic [1:0]  w_cyc_addr;
  logic [7:0]  w_cyc_wdata;
  logic [7:0]  w_rdata;
  logic [15:0] w_acc_next;

  assign cmd_ready = ~r_busy;
  assign w_accept  = cmd_valid & ~r_busy;
  assign w_err     = (cmd_counter == 2'd3) || (cmd_op == OP_RSVD);
  assign w_num_new = total_cycles(cmd_op, cmd_rw);
  assign w_more    = (r_idx + 2'd1) < r_num;

  // The first bus cycle is issued on the accepting edge straight from the
  // cmd_* inputs so SETUP lands in the very next clock; later cycles are
  // issued from the captured copy when the engine signals done.
  assign w_start = (w_accept && !w_err && (w_num_new != 2'd0)) ||
                   (r_busy && w_done && w_more);

  // Describe the bus cycle about to be issued. PROGRAM and READ carry a
  // control/latch word first; the remaining cycles move the data bytes,
  // LSB first unless RL selects MSB only.
  always_comb begin
    w_sel_op      = w_accept ? cmd_op      : r_op;
    w_sel_counter = w_accept ? cmd_counter : r_counter;
    w_sel_rw      = w_accept ? cmd_rw      : r_rw;
    w_sel_mode    = w_accept ? cmd_mode    : r_mode;
    w_sel_bcd     = w_accept ? cmd_bcd     : r_bcd;
    w_sel_count   = w_accept ? cmd_count   : r_count;
    w_next_idx    = w_accept ? 2'd0 : (r_idx + 2'd1);
    w_has_prefix  = (w_sel_op != OP_RELOAD);
    w_data_pos    = w_next_idx - (w_has_prefix ? 2'd1 : 2'd0);
    w_cyc_msb     = (w_sel_rw == RL_MSB) || (w_data_pos == 2'd1);
    w_cyc_read    = 1'b0;
    w_cyc_addr    = ADDR_CONTROL;
    w_cyc_wdata   = 8'd0;
    if (w_has_prefix && (w_next_idx == 2'd0)) begin
      w_cyc_msb = 1'b0;
      if (w_sel_op == OP_READ)
        w_cyc_wdata = pack_control_word(w_sel_counter, RL_LATCH, 3'b000, 1'b0);
      else
        w_cyc_wdata = pack_control_word(w_sel_counter, w_sel_rw, w_sel_mode, w_sel_bcd);
    end else begin
      w_cyc_addr = w_sel_counter;
      w_cyc_read = (w_sel_op == OP_READ);
      if (!w_cyc_read)
        w_cyc_wdata = w_cyc_msb ? w_sel_count[15:8] : w_sel_count[7:0];
    end
  end

  // Merge the byte from a completed read cycle into the 16-bit result.
  always_comb begin
    w_acc_next = r_rd_acc;
    if (r_cur_read) begin
      if (r_cur_msb) w_acc_next = {w_rdata, r_rd_acc[7:0]};
      else           w_acc_next = {r_rd_acc[15:8], w_rdata};
    end
  end

  // Command sequencer: captures the command, steps through its bus cycles
  // and raises the response pulse one clock after the final RECOVER.
  // Rejected commands and RELOAD with RL=00 respond immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op        <= 2'd0;
      r_counter   <= 2'd0;
      r_rw        <= 2'd0;
      r_mode      <= 3'd0;
      r_bcd       <= 1'b0;
      r_count     <= 16'd0;
      r_idx       <= 2'd0;
      r_num       <= 2'd0;
      r_cur_read  <= 1'b0;
      r_cur_msb   <= 1'b0;
      r_rd_acc    <= 16'd0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_data  <= 16'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_data  <= 16'd0;
      if (w_accept) begin
        r_op      <= cmd_op;
        r_counter <= cmd_counter;
        r_rw      <= cmd_rw;
        r_mode    <= cmd_mode;
        r_bcd     <= cmd_bcd;
        r_count   <= cmd_count;
        r_rd_acc  <= 16'd0;
        if (w_err || (w_num_new == 2'd0)) begin
          r_rsp_valid <= 1'b1;
          r_rsp_error <= w_err;
        end else begin
          r_busy     <= 1'b1;
          r_idx      <= 2'd0;
          r_num      <= w_num_new;
          r_cur_read <= w_cyc_read;
          r_cur_msb  <= w_cyc_msb;
        end
      end else if (r_busy && w_done) begin
        r_rd_acc <= w_acc_next;
        if (w_more) begin
          r_idx      <= r_idx + 2'd1;
          r_cur_read <= w_cyc_read;
          r_cur_msb  <= w_cyc_msb;
        end else begin
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= (r_op == OP_READ) ? w_acc_next : 16'd0;
        end
      end
    end
  end

  kf8253_bus_cycle #(
    .STROBE_CYCLES  (STROBE_CYCLES),
    .RECOVERY_CYCLES(RECOVERY_CYCLES)
  ) u_bus_cycle (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_start    (w_start),
    .i_is_read  (w_cyc_read),
    .i_address  (w_cyc_addr),
    .i_wdata    (w_cyc_wdata),
    .i_rdata_bus(data_bus_in),
    .o_cs_n     (chip_select_n),
    .o_rd_n     (read_enable_n),
    .o_wr_n     (write_enable_n),
    .o_address  (address),
    .o_wdata_bus(data_bus_out),
    .o_rdata    (w_rdata),
    .o_done     (w_done)
  );

  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_error = r_rsp_error;
  assign rsp_data  = r_rsp_data;

endmodule
